// File: rtl/demultiplexer_frame_loader_pkg.sv
// Shared constants and FSM encoding for the serial-to-16-channel frame loader.
package demultiplexer_frame_loader_pkg;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned PTR_W = 4;

    // Pointer value of the final channel in a frame.
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_CH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/decoder_4to16.sv
// 4-bit index plus enable to 16-bit one-hot; all-zero when disabled.
module decoder_4to16
    import demultiplexer_frame_loader_pkg::*;
(
    input  logic [PTR_W-1:0] idx,
    input  logic             en,
    output logic [N_CH-1:0]  onehot
);

    // Single bit set at idx only while enabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/demultiplexer_frame_loader.sv
// Routes a serial bit stream into 16 registered channels, either as a
// sequential frame (start + din_valid) or by direct indexed writes in idle.
module demultiplexer_frame_loader
    import demultiplexer_frame_loader_pkg::*;
#(
    parameter bit CLEAR_ON_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             start,
    input  logic             wr,
    input  logic [PTR_W-1:0] sel,
    output logic [N_CH-1:0]  Q,
    output logic [N_CH-1:0]  ch_strobe,
    output logic             busy,
    output logic             frame_done
);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  q_q, q_d;
    logic             clear;
    logic             dec_en;
    logic [PTR_W-1:0] dec_idx;
    logic [N_CH-1:0]  dec_onehot;

    // Next-state, pointer and write-select decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clear   = 1'b0;
        dec_en  = 1'b0;
        dec_idx = ptr_q;
        unique case (state_q)
            StIdle: begin
                // start has priority over a simultaneous direct write
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    clear   = CLEAR_ON_START;
                end else if (wr) begin
                    dec_en  = 1'b1;
                    dec_idx = sel;
                end
            end
            StLoad: begin
                if (din_valid) begin
                    dec_en = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Gating with rst_n keeps the strobe quiet while reset is held,
    // even if wr is asserted in the reset state.
    decoder_4to16 u_decoder (
        .idx    (dec_idx),
        .en     (dec_en & rst_n),
        .onehot (dec_onehot)
    );

    // Channel register next value: optional clear, then per-bit write enables.
    always_comb begin
        q_d = clear ? '0 : q_q;
        q_d = (q_d & ~dec_onehot) | ({N_CH{din}} & dec_onehot);
    end

    // State, pointer and channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
        end
    end

    assign Q          = q_q;
    assign ch_strobe  = dec_onehot;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_demultiplexer_frame_loader.sv
// Bench for demultiplexer_frame_loader: a clearing and a non-clearing instance
// share stimulus; a behavioural model checks every cycle and a scoreboard
// checks final frame contents and latency at each frame_done.
module tb_demultiplexer_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din, din_valid, start, wr;
    logic [3:0]  sel;
    logic [15:0] q_a, q_b, strobe_a, strobe_b;
    logic        busy_a, busy_b, fd_a, fd_b;

    demultiplexer_frame_loader #(.CLEAR_ON_START(1'b1)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .start      (start),
        .wr         (wr),
        .sel        (sel),
        .Q          (q_a),
        .ch_strobe  (strobe_a),
        .busy       (busy_a),
        .frame_done (fd_a)
    );

    demultiplexer_frame_loader #(.CLEAR_ON_START(1'b0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .start      (start),
        .wr         (wr),
        .sel        (sel),
        .Q          (q_b),
        .ch_strobe  (strobe_b),
        .busy       (busy_b),
        .frame_done (fd_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Behavioural model: 0 idle, 1 load, 2 done.
    int          m_state = 0;
    logic [3:0]  m_ptr = '0;
    logic [15:0] m_q = '0;
    logic [15:0] m_qb = '0;
    logic [15:0] last_strobe;

    typedef struct {
        logic [15:0] q;
        int          len;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [3:0]  sel;
        logic        d;
        logic [15:0] strobe;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a falling edge: drive, check this cycle, advance model, cross one rising edge.
    task automatic step(input logic d, input logic v, input logic s, input logic w,
                        input logic [3:0] sl);
        logic [15:0] exp_strobe;
        sb_t         e;
        din = d; din_valid = v; start = s; wr = w; sel = sl;
        #1;
        exp_strobe = '0;
        if (m_state == 0 && !s && w) exp_strobe[sl] = 1'b1;
        else if (m_state == 1 && v) exp_strobe[m_ptr] = 1'b1;
        last_strobe = strobe_a;
        chk("ch_strobe", strobe_a, exp_strobe);
        chk("ch_strobe_noclr", strobe_b, exp_strobe);
        chk("strobe_popcount_le1", 16'($countones(strobe_a) <= 1), 16'd1);
        chk("Q", q_a, m_q);
        chk("Q_noclr", q_b, m_qb);
        chk("busy", 16'(busy_a), 16'(m_state != 0));
        chk("busy_noclr", 16'(busy_b), 16'(m_state != 0));
        chk("frame_done", 16'(fd_a), 16'(m_state == 2));
        chk("frame_done_noclr", 16'(fd_b), 16'(m_state == 2));
        if (fd_a) begin
            chk("frame_done_expected", 16'(sb.size() != 0), 16'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("frame_q", q_a, e.q);
                chk("frame_len", 16'(cyc - start_cyc), 16'(e.len));
            end
        end
        case (m_state)
            0: begin
                if (s) begin
                    m_state = 1;
                    m_ptr   = '0;
                    m_q     = '0;
                end else if (w) begin
                    m_q[sl]  = d;
                    m_qb[sl] = d;
                end
            end
            1: begin
                if (v) begin
                    m_q[m_ptr]  = d;
                    m_qb[m_ptr] = d;
                    if (m_ptr == 4'hF) m_state = 2;
                    m_ptr = m_ptr + 4'd1;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Start, 16 valid bits (ch0 first), optional gap, then done and idle cycles.
    task automatic run_frame(input logic [15:0] pattern, input int gap_after,
                             input int gap_len, input logic wr_with_start);
        sb.push_back('{q: pattern, len: 17 + gap_len});
        start_cyc = cyc;
        step(1'b1, 1'b0, 1'b1, wr_with_start, 4'hA);
        for (int i = 0; i < 16; i++) begin
            step(pattern[i], 1'b1, 1'b0, 1'b0, 4'h0);
            if (i == gap_after - 1) begin
                // start/wr must be ignored while loading
                for (int g = 0; g < gap_len; g++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'h2);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{sel: 4'hA, d: 1'b1, strobe: 16'h0400};
        tbl[1] = '{sel: 4'h0, d: 1'b1, strobe: 16'h0001};
        tbl[2] = '{sel: 4'hF, d: 1'b1, strobe: 16'h8000};
        tbl[3] = '{sel: 4'h3, d: 1'b1, strobe: 16'h0008};
        tbl[4] = '{sel: 4'hA, d: 1'b0, strobe: 16'h0400};
        tbl[5] = '{sel: 4'h5, d: 1'b1, strobe: 16'h0020};

        // Reset held with wr asserted: outputs cleared, no strobe.
        rst_n = 1'b0; din = 1'b1; din_valid = 1'b1; start = 1'b0; wr = 1'b1; sel = 4'h3;
        #2;
        chk("reset_Q", q_a, 16'h0000);
        chk("reset_Q_noclr", q_b, 16'h0000);
        chk("reset_strobe", strobe_a, 16'h0000);
        chk("reset_busy", 16'(busy_a), 16'd0);
        chk("reset_frame_done", 16'(fd_a), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start on the first edge after reset; gapless frame.
        run_frame(16'hCF05, 0, 0, 1'b0);
        chk("gapless_Q", q_a, 16'hCF05);

        // Table-driven direct writes in idle.
        for (int t = 0; t < 6; t++) begin
            step(tbl[t].d, 1'b0, 1'b0, 1'b1, tbl[t].sel);
            chk("tbl_strobe", last_strobe, tbl[t].strobe);
            chk("tbl_qbit", 16'(q_a[tbl[t].sel]), 16'(tbl[t].d));
        end
        // din_valid alone in idle does nothing.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        chk("idle_valid_no_strobe", last_strobe, 16'h0000);

        // Direct write to ch10, then start+wr together: start wins.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'hA);
        chk("wr_sel_a_strobe", last_strobe, 16'h0400);
        chk("wr_sel_a_bit", 16'(q_a[10]), 16'd1);
        // Same frame with a 3-cycle din_valid gap after bit 7.
        run_frame(16'hCF05, 7, 3, 1'b1);
        chk("gapped_Q", q_a, 16'hCF05);

        // Reset mid-cycle after bit 5 of a frame.
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) step(1'(i % 2), 1'b1, 1'b0, 1'b0, 4'h0);
        #2;
        din = 1'b1; din_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreset_Q", q_a, 16'h0000);
        chk("midreset_Q_noclr", q_b, 16'h0000);
        chk("midreset_busy", 16'(busy_a), 16'd0);
        chk("midreset_frame_done", 16'(fd_a), 16'd0);
        chk("midreset_strobe", strobe_a, 16'h0000);
        m_state = 0; m_ptr = '0; m_q = '0; m_qb = '0;
        @(negedge clk);
        chk("reset_held_frame_done", 16'(fd_a), 16'd0);
        chk("reset_held_busy", 16'(busy_a), 16'd0);
        rst_n = 1'b1;
        run_frame(16'h1234, 0, 0, 1'b0);
        chk("after_reset_Q", q_a, 16'h1234);

        // Non-clearing instance: preset all ones, then load a frame of zeros.
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 4'(k));
        chk("preset_ffff", q_b, 16'hFFFF);
        run_frame(16'h0000, 0, 0, 1'b0);
        chk("noclr_final", q_b, 16'h0000);

        chk("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
